audio_fx_controller: RTL and testbench

Front-panel controller that sequences the audio effects datapath. It debounces three pushbuttons and steps an effect-mode state machine (MUTE → SINE → FEEDBACK → MUTE), with an optional auto-cycle mode. It drives the effects block's `control[3:0]` and `volume_control[3:0]` inputs, and applies mode changes only on sample boundaries so no sample is produced under a half-changed selection.

---
 rtl/audio_fx_controller_pkg.sv | 42 ++++
 rtl/audio_fx_controller_if.sv | 28 ++
 rtl/audio_fx_controller_button_debounce.sv | 63 ++++++
 rtl/audio_fx_controller.sv | 117 +++++++++++
 tb/tb_audio_fx_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_fx_controller_pkg.sv
// Purpose: shared encodings and helpers for the audio effects front-panel controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package audio_fx_controller_pkg;

   // Effect-mode state encodings, also driven out on the mode port.
   localparam logic [1:0] MODE_MUTE     = 2'd0;
   localparam logic [1:0] MODE_SINE     = 2'd1;
   localparam logic [1:0] MODE_FEEDBACK = 2'd2;

   // Bit positions inside the datapath's control word; these have to line up
   // with how the effects block decodes control[3:0].
   localparam int CTRL_SINE     = 0;
   localparam int CTRL_FEEDBACK = 1;

   // Volume range accepted by the datapath.
   localparam logic [3:0] VOL_MIN = 4'd0;
   localparam logic [3:0] VOL_MAX = 4'd15;

   // Advance order MUTE -> SINE -> FEEDBACK -> MUTE; the unused encoding
   // falls back to MUTE so a corrupted state recovers at the next boundary.
   function automatic logic [1:0] next_mode(input logic [1:0] cur);
      logic [1:0] nxt;
      case (cur)
         MODE_MUTE: nxt = MODE_SINE;
         MODE_SINE: nxt = MODE_FEEDBACK;
         default:   nxt = MODE_MUTE;
      endcase
      return nxt;
   endfunction

   // One-hot effect select for a given mode; MUTE (and anything illegal)
   // selects nothing, and bits 3:2 are never used.
   function automatic logic [3:0] mode_ctrl(input logic [1:0] m);
      logic [3:0] c;
      c = 4'b0000;
      if (m == MODE_SINE)     c[CTRL_SINE]     = 1'b1;
      if (m == MODE_FEEDBACK) c[CTRL_FEEDBACK] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/audio_fx_controller_if.sv
// Purpose: bundles the panel inputs and the datapath-facing outputs of the controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface audio_fx_controller_if;

   logic       btn_mode;
   logic       btn_vol_up;
   logic       btn_vol_down;
   logic       auto_en;
   logic       sample_req;
   logic [3:0] control;
   logic [3:0] volume_control;
   logic [1:0] mode;
   logic       change_pending;

   // Panel / codec side that drives the controller.
   modport master (
      output btn_mode, btn_vol_up, btn_vol_down, auto_en, sample_req,
      input  control, volume_control, mode, change_pending
   );

   // The controller itself.
   modport slave (
      input  btn_mode, btn_vol_up, btn_vol_down, auto_en, sample_req,
      output control, volume_control, mode, change_pending
   );

endinterface

// File: rtl/audio_fx_controller_button_debounce.sv
// Purpose: synchronise and debounce one raw pushbutton, emit a pulse on each accepted press.
// Latency: button edge to o_press = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; o_press is a single-cycle pulse that must be consumed when seen.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync0;
   logic          r_sync1;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_level_d;
   logic          r_press;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= i_btn;
         r_sync1 <= r_sync0;
      end
   end

   // Count how long the synchronised level has differed from the accepted
   // level; any return to the accepted level (i.e. a bounce) restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_sync1 == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
         r_level <= r_sync1;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Registered rising-edge detect on the debounced level gives the press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/audio_fx_controller.sv
// Purpose: front-panel controller stepping the effect mode and volume of the audio datapath.
// Latency: press pulse -> change_pending 1 cycle; mode/control update on the sample_req edge; volume 1 cycle after press.
// Backpressure: advance requests wait in a single pending flag until a sample boundary; extra requests are absorbed.
module audio_fx_controller
   import audio_fx_controller_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         AUTO_SAMPLES    = 48000,
   parameter logic [3:0] VOL_RESET       = 4'd8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   audio_fx_controller_if.slave  io_fx
);

   localparam int AW = (AUTO_SAMPLES > 1) ? $clog2(AUTO_SAMPLES) : 1;
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_SAMPLES - 1);

   logic          w_press_mode;
   logic          w_press_up;
   logic          w_press_down;
   logic          w_auto_tick;
   logic          w_req;
   logic          w_apply;
   logic [1:0]    w_next_mode;
   logic          w_vol_inc;
   logic          w_vol_dec;

   logic [1:0]    r_mode;
   logic [3:0]    r_control;
   logic          r_pending;
   logic [AW-1:0] r_auto_cnt;
   logic [3:0]    r_volume;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (io_fx.btn_mode),
      .o_press (w_press_mode)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (io_fx.btn_vol_up),
      .o_press (w_press_up)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (io_fx.btn_vol_down),
      .o_press (w_press_down)
   );

   // The auto tick is combinational so that it lands on the very boundary
   // that completes the count and is applied there.
   assign w_auto_tick = io_fx.auto_en & io_fx.sample_req & (r_auto_cnt == AUTO_LAST);

   // A press and a tick in the same cycle merge into one request; a request
   // that coincides with sample_req is applied at that same boundary.
   assign w_req       = w_press_mode | w_auto_tick;
   assign w_apply     = io_fx.sample_req & (r_pending | w_req);
   assign w_next_mode = next_mode(r_mode);

   // Simultaneous up and down cancel; saturation is checked before stepping.
   assign w_vol_inc = w_press_up & ~w_press_down & (r_volume != VOL_MAX);
   assign w_vol_dec = w_press_down & ~w_press_up & (r_volume != VOL_MIN);

   // Auto-cycle sample counter: held at zero while auto-cycling is off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_auto_cnt <= '0;
      end else if (!io_fx.auto_en) begin
         r_auto_cnt <= '0;
      end else if (io_fx.sample_req) begin
         if (r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt <= '0;
         end else begin
            r_auto_cnt <= r_auto_cnt + AW'(1);
         end
      end
   end

   // Mode FSM with pending flag: only ever steps on a sample boundary, so the
   // datapath never sees control change in the middle of a sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= MODE_MUTE;
         r_control <= 4'b0000;
         r_pending <= 1'b0;
      end else if (w_apply) begin
         r_mode    <= w_next_mode;
         r_control <= mode_ctrl(w_next_mode);
         r_pending <= 1'b0;
      end else if (w_req) begin
         r_pending <= 1'b1;
      end
   end

   // Volume register, updated straight from the press pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_volume <= VOL_RESET;
      end else if (w_vol_inc) begin
         r_volume <= r_volume + 4'd1;
      end else if (w_vol_dec) begin
         r_volume <= r_volume - 4'd1;
      end
   end

   assign io_fx.control        = r_control;
   assign io_fx.mode           = r_mode;
   assign io_fx.change_pending = r_pending;
   assign io_fx.volume_control = r_volume;

endmodule

// File: tb/tb_audio_fx_controller.sv
// Purpose: directed self-checking bench for audio_fx_controller with a mode-change scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_fx_controller;

   localparam int DEB  = 4;
   localparam int AUTO = 3;

   logic clk;
   logic rst_n;

   int   checks;
   int   failures;
   int   pend_rises;

   logic [1:0] exp_q[$];
   logic [1:0] m_mode;
   logic       m_pend;
   logic [3:0] m_vol;
   logic       m_auto_en;
   int         m_auto_cnt;

   audio_fx_controller_if fx();

   audio_fx_controller #(
      .DEBOUNCE_CYCLES (DEB),
      .AUTO_SAMPLES    (AUTO),
      .VOL_RESET       (4'd8)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_fx (fx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_ctrl(input logic [1:0] m);
      case (m)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0010;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [1:0] exp_next(input logic [1:0] m);
      if (m == 2'd0) return 2'd1;
      if (m == 2'd1) return 2'd2;
      return 2'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
   endtask

   task automatic model_reset();
      m_mode     = 2'd0;
      m_pend     = 1'b0;
      m_vol      = 4'd8;
      m_auto_cnt = 0;
   endtask

   // Called just after a negedge: pulses sample_req for one cycle.
   task automatic boundary(input string tag, input bit req_now);
      bit tick;
      fx.sample_req = 1'b1;
      check({tag, "_ctrl_before"}, 32'(fx.control), 32'(exp_ctrl(m_mode)));
      tick = 1'b0;
      if (m_auto_en) begin
         tick = (m_auto_cnt == AUTO - 1);
         m_auto_cnt = tick ? 0 : m_auto_cnt + 1;
      end
      if (m_pend || req_now || tick) begin
         m_mode = exp_next(m_mode);
         exp_q.push_back(m_mode);
         m_pend = 1'b0;
      end
      @(negedge clk);
      fx.sample_req = 1'b0;
      check({tag, "_ctrl_after"}, 32'(fx.control), 32'(exp_ctrl(m_mode)));
      check({tag, "_mode_after"}, 32'(fx.mode), 32'(m_mode));
      check({tag, "_pend_after"}, 32'(fx.change_pending), 32'(m_pend));
   endtask

   // Called just after a negedge: clean press of the selected buttons, with
   // latency checks around the press pulse; optionally a sample boundary
   // coinciding with the pulse cycle.
   task automatic press(input string tag, input bit m, input bit up, input bit dn,
                        input bit with_sample);
      logic [3:0] v_new;
      fx.btn_mode     = m;
      fx.btn_vol_up   = up;
      fx.btn_vol_down = dn;
      repeat (7) @(negedge clk);
      check({tag, "_vol_pre"},  32'(fx.volume_control), 32'(m_vol));
      check({tag, "_pend_pre"}, 32'(fx.change_pending), 32'(m_pend));
      v_new = m_vol;
      if (up && !dn && m_vol != 4'd15) v_new = m_vol + 4'd1;
      if (dn && !up && m_vol != 4'd0)  v_new = m_vol - 4'd1;
      if (with_sample) begin
         boundary({tag, "_bnd"}, m);
      end else begin
         @(negedge clk);
         if (m) m_pend = 1'b1;
      end
      m_vol = v_new;
      check({tag, "_vol"},  32'(fx.volume_control), 32'(m_vol));
      check({tag, "_pend"}, 32'(fx.change_pending), 32'(m_pend));
      repeat (2) @(negedge clk);
      fx.btn_mode     = 1'b0;
      fx.btn_vol_up   = 1'b0;
      fx.btn_vol_down = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Scoreboard monitor: every observed mode change must match the next queued expectation.
   initial begin
      logic [1:0] last_mode;
      logic       last_pend;
      logic [1:0] e;
      pend_rises = 0;
      last_mode  = 2'd0;
      last_pend  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (fx.mode !== last_mode) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_mode_change", 32'(fx.mode), 32'(last_mode));
               end else begin
                  e = exp_q.pop_front();
                  check("scoreboard_mode", 32'(fx.mode), 32'(e));
               end
            end
            if (fx.change_pending === 1'b1 && last_pend === 1'b0) pend_rises++;
         end
         last_mode = fx.mode;
         last_pend = fx.change_pending;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks          = 0;
      failures        = 0;
      m_auto_en       = 1'b0;
      fx.btn_mode     = 1'b0;
      fx.btn_vol_up   = 1'b0;
      fx.btn_vol_down = 1'b0;
      fx.auto_en      = 1'b0;
      fx.sample_req   = 1'b0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_control", 32'(fx.control), 32'h0);
      check("rst_mode",    32'(fx.mode), 32'h0);
      check("rst_volume",  32'(fx.volume_control), 32'h8);
      check("rst_pending", 32'(fx.change_pending), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Bounce rejection: 2-cycle toggling never survives the debounce window.
      for (int i = 0; i < 5; i++) begin
         fx.btn_mode = 1'b1;
         repeat (2) @(negedge clk);
         fx.btn_mode = 1'b0;
         repeat (2) @(negedge clk);
      end
      check("bounce_pend_during", 32'(fx.change_pending), 32'h0);
      fx.btn_mode = 1'b1;
      repeat (10) @(negedge clk);
      check("bounce_pend_set", 32'(fx.change_pending), 32'h1);
      fx.btn_mode = 1'b0;
      repeat (10) @(negedge clk);
      check("bounce_one_rise", 32'(pend_rises), 32'd1);
      m_pend = 1'b1;

      // Boundary alignment: control holds MUTE until the sample_req edge.
      for (int i = 0; i < 10; i++) begin
         check("align_hold_ctrl", 32'(fx.control), 32'h0);
         @(negedge clk);
      end
      boundary("align", 1'b0);

      // Asynchronous reset mid-run discards the pending advance and volume.
      press("pre_rst_up", 1'b0, 1'b1, 1'b0, 1'b0);
      press("pre_rst_mode", 1'b1, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_control", 32'(fx.control), 32'h0);
      check("midrst_mode",    32'(fx.mode), 32'h0);
      check("midrst_volume",  32'(fx.volume_control), 32'h8);
      check("midrst_pending", 32'(fx.change_pending), 32'h0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("postrst_pending", 32'(fx.change_pending), 32'h0);

      // Absorption and wrap: two presses give one advance, then full cycle.
      press("abs1", 1'b1, 1'b0, 1'b0, 1'b0);
      press("abs2", 1'b1, 1'b0, 1'b0, 1'b0);
      boundary("abs_bnd", 1'b0);
      for (int i = 0; i < 3; i++) begin
         press("wrap_press", 1'b1, 1'b0, 1'b0, 1'b0);
         boundary("wrap_bnd", 1'b0);
      end

      // Back to MUTE for auto-cycling.
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Auto-cycle: advance on every third sample boundary.
      fx.auto_en = 1'b1;
      m_auto_en  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         boundary("auto", 1'b0);
         repeat (2) @(negedge clk);
      end
      check("auto_mode_after9", 32'(fx.mode), 32'h0);
      boundary("auto10", 1'b0);
      boundary("auto11", 1'b0);
      press("auto_tick_press", 1'b1, 1'b0, 1'b0, 1'b1);
      check("auto_tick_single", 32'(fx.mode), 32'h1);
      fx.auto_en = 1'b0;
      m_auto_en  = 1'b0;
      m_auto_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         boundary("auto_off", 1'b0);
      end

      // Volume saturation at both ends, and cancelling simultaneous presses.
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) press("vol_up", 1'b0, 1'b1, 1'b0, 1'b0);
      check("vol_max", 32'(fx.volume_control), 32'd15);
      for (int i = 0; i < 20; i++) press("vol_down", 1'b0, 1'b0, 1'b1, 1'b0);
      check("vol_min", 32'(fx.volume_control), 32'd0);
      press("vol_both", 1'b0, 1'b1, 1'b1, 1'b0);
      check("vol_both_hold", 32'(fx.volume_control), 32'd0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
